// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, feeder FSM states and TX datapath mux selects.
// No logic lives here. Every item is a constant or a type.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

    // Serializer output mux selects; the TX FSM steps through these per frame
    localparam logic [1:0] TX_SEL_START  = 2'd0;
    localparam logic [1:0] TX_SEL_DATA   = 2'd1;
    localparam logic [1:0] TX_SEL_PARITY = 2'd2;
    localparam logic [1:0] TX_SEL_STOP   = 2'd3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered read port; a pop loads o_rd_dat on the popping edge.
// A push while full or a pop while empty is ignored, and the level comes from a counter.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rd_dat,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int LVL_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [DATA_WIDTH-1:0] r_rd_dat;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // Storage has no reset so it can map onto a register file or RAM
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rd_dat <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_dat <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_dat = r_rd_dat;
    assign o_level  = r_level;
    assign o_full   = w_full;
    assign o_empty  = w_empty;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches each one into the UART TX FSM only when it is idle. TxDataValid rises 2 cycles after a push into an empty FIFO.
// InReady = !Full; FEEDER_TIMEOUT_EN adds a sticky Timeout when TxBusy never answers a launch.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int DEPTH      = 16,
`ifdef FEEDER_TIMEOUT_EN
    parameter  int TIMEOUT    = 15,
`endif
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] InData,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  TxBusy,
    output logic [DATA_WIDTH-1:0] TxData,
    output logic                  TxDataValid,
    output logic [ADDR_WIDTH:0]   Level,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Timeout
);

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;

    logic                  w_pop;
    logic                  r_pop_d;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_vld;
    logic [DATA_WIDTH-1:0] w_fifo_dat;
    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_full;
    logic                  w_empty;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .i_push     (InValid),
        .i_push_dat (InData),
        .i_pop      (w_pop),
        .o_rd_dat   (w_fifo_dat),
        .o_level    (w_level),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

`ifdef FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_timeout_hit;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        w_timeout_hit = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty && !TxBusy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Busy is only meaningful once the byte has actually been presented
                if (!r_pop_d && TxBusy) begin
                    w_state_nxt = WAIT_DONE;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = IDLE;
                end
`endif
            end
            WAIT_DONE: begin
                if (!TxBusy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read data lands one edge after the pop, so the launch pulse follows r_pop_d
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_pop_d   <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pop_d  <= w_pop;
            r_tx_vld <= r_pop_d;
            if (r_pop_d) begin
                r_tx_data <= w_fifo_dat;
            end
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == WAIT_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign Timeout = r_timeout;
`else
    assign Timeout = 1'b0;
`endif

    assign InReady     = !w_full;
    assign TxData      = r_tx_data;
    assign TxDataValid = r_tx_vld;
    assign Level       = w_level;
    assign Full        = w_full;
    assign Empty       = w_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: latency, TX handshake, fill/overflow, full pop+push, reset, optional timeout.
module tb_uart_tx_feeder;

    localparam int TB_DEPTH = 16;
`ifdef FEEDER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 15;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] InData;
    logic       InValid;
    logic       InReady;
    logic [7:0] TxData;
    logic       TxDataValid;
    logic [4:0] Level;
    logic       Full;
    logic       Empty;
    logic       Timeout;

    logic tb_busy;
    logic model_busy;
    bit   model_en;
    int   model_left;
    wire  TxBusy = model_en ? model_busy : tb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_feeder dut (
        .CLK         (CLK),
        .RST         (RST),
        .InData      (InData),
        .InValid     (InValid),
        .InReady     (InReady),
        .TxBusy      (TxBusy),
        .TxData      (TxData),
        .TxDataValid (TxDataValid),
        .Level       (Level),
        .Full        (Full),
        .Empty       (Empty),
        .Timeout     (Timeout)
    );

    always #5 CLK = ~CLK;

    // TX FSM stand-in: Busy rises after a launch pulse and stays high for 11 cycles
    always @(negedge CLK) begin
        if (!model_en) begin
            model_busy = 1'b0;
            model_left = 0;
        end else if (TxDataValid) begin
            model_busy = 1'b1;
            model_left = 11;
        end else if (model_left > 0) begin
            model_left = model_left - 1;
            if (model_left == 0) model_busy = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        InValid = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        InData  = d;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
    endtask

    task automatic test_reset;
        model_en = 1'b0;
        tb_busy  = 1'b0;
        InData   = 8'h00;
        InValid  = 1'b0;
        RST      = 1'b1;
        tick();
        tick();
        n_tests++; if (TxData !== 8'h00) begin n_fail++; $display("FAIL reset_txdata: got %h want 00", TxData); end
        n_tests++; if (TxDataValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", TxDataValid); end
        n_tests++; if (Level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", Level); end
        n_tests++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", Empty); end
        n_tests++; if (Full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", Full); end
        n_tests++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b want 1", InReady); end
        n_tests++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
        RST = 1'b0;
    endtask

    task automatic test_single_launch;
        do_reset();
        tb_busy = 1'b0;
        push_byte(8'hA5);
        n_tests++; if (Empty !== 1'b0 || Level !== 5'd1) begin n_fail++; $display("FAIL single_after_push: empty=%b level=%0d want 0/1", Empty, Level); end
        tick();
        n_tests++; if (TxDataValid !== 1'b0 || Level !== 5'd0) begin n_fail++; $display("FAIL single_pop_cycle: valid=%b level=%0d want 0/0", TxDataValid, Level); end
        tick();
        n_tests++; if (TxDataValid !== 1'b1 || TxData !== 8'hA5) begin n_fail++; $display("FAIL single_launch: valid=%b data=%h want 1/a5", TxDataValid, TxData); end
        tick();
        n_tests++; if (TxDataValid !== 1'b0 || TxData !== 8'hA5) begin n_fail++; $display("FAIL single_pulse_width: valid=%b data=%h want 0/a5", TxDataValid, TxData); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got [3];
        logic [7:0] cur;
        int   npulse = 0;
        int   wide = 0;
        int   early = 0;
        int   unstable = 0;
        logic prev_vld = 1'b0;
        logic have = 1'b0;
        logic busy_seen = 1'b0;
        do_reset();
        model_en = 1'b1;
        cur = 8'h00;
        InValid = 1'b1;
        InData = 8'h11; tick();
        InData = 8'h22; tick();
        InData = 8'h33; tick();
        InValid = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (TxBusy) busy_seen = 1'b1;
            if (TxDataValid) begin
                if (prev_vld) wide++;
                if (TxBusy || (npulse > 0 && !busy_seen)) early++;
                if (npulse < 3) got[npulse] = TxData;
                npulse++;
                cur = TxData;
                have = 1'b1;
                busy_seen = 1'b0;
            end
            if (TxBusy && have && TxData !== cur) unstable++;
            prev_vld = TxDataValid;
            tick();
        end
        n_tests++; if (npulse != 3) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want 3", npulse); end
        if (npulse >= 3) begin
            n_tests++; if (got[0] !== 8'h11) begin n_fail++; $display("FAIL b2b_byte0: got %h want 11", got[0]); end
            n_tests++; if (got[1] !== 8'h22) begin n_fail++; $display("FAIL b2b_byte1: got %h want 22", got[1]); end
            n_tests++; if (got[2] !== 8'h33) begin n_fail++; $display("FAIL b2b_byte2: got %h want 33", got[2]); end
        end
        n_tests++; if (wide != 0) begin n_fail++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", wide); end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL b2b_launch_while_busy: got %0d want 0", early); end
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL b2b_data_stable: got %0d changes want 0", unstable); end
        model_en = 1'b0;
    endtask

    task automatic test_fill_overflow;
        do_reset();
        tb_busy = 1'b1;
        InValid = 1'b1;
        for (int i = 0; i < TB_DEPTH + 2; i++) begin
            InData = 8'h40 + 8'(i);
            tick();
            if (i == TB_DEPTH - 2) begin
                n_tests++; if (Full !== 1'b0 || InReady !== 1'b1 || Level !== 5'd15) begin n_fail++; $display("FAIL fill_almost: full=%b rdy=%b level=%0d want 0/1/15", Full, InReady, Level); end
            end
            if (i == TB_DEPTH - 1) begin
                n_tests++; if (Full !== 1'b1 || InReady !== 1'b0 || Level !== 5'd16) begin n_fail++; $display("FAIL fill_full: full=%b rdy=%b level=%0d want 1/0/16", Full, InReady, Level); end
            end
        end
        InValid = 1'b0;
        n_tests++; if (Level !== 5'd16 || Full !== 1'b1 || Empty !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: level=%0d full=%b empty=%b want 16/1/0", Level, Full, Empty); end
    endtask

    task automatic test_full_pop_push;
        logic [7:0] got [16];
        int npulse = 0;
        tb_busy = 1'b0;
        InValid = 1'b1;
        InData  = 8'hEE;
        tick();
        n_tests++; if (Level !== 5'd15 || Full !== 1'b0 || InReady !== 1'b1) begin n_fail++; $display("FAIL fullpop_refused: level=%0d full=%b rdy=%b want 15/0/1", Level, Full, InReady); end
        InData = 8'h77;
        tick();
        InValid = 1'b0;
        n_tests++; if (Level !== 5'd16 || Full !== 1'b1) begin n_fail++; $display("FAIL fullpop_accept: level=%0d full=%b want 16/1", Level, Full); end
        n_tests++; if (TxDataValid !== 1'b1 || TxData !== 8'h40) begin n_fail++; $display("FAIL fullpop_launch: valid=%b data=%h want 1/40", TxDataValid, TxData); end
        // Walk the FSM back to IDLE, then let the TX model drain the rest
        tb_busy = 1'b1; tick(); tick();
        tb_busy = 1'b0; tick();
        model_en = 1'b1;
        for (int c = 0; c < 320; c++) begin
            if (TxDataValid) begin
                if (npulse < 16) got[npulse] = TxData;
                npulse++;
            end
            tick();
        end
        n_tests++; if (npulse != 16) begin n_fail++; $display("FAIL fullpop_drain_count: got %0d want 16", npulse); end
        if (npulse >= 16) begin
            n_tests++; if (got[0] !== 8'h41) begin n_fail++; $display("FAIL fullpop_drain_first: got %h want 41", got[0]); end
            n_tests++; if (got[14] !== 8'h4F) begin n_fail++; $display("FAIL fullpop_drain_mid: got %h want 4f", got[14]); end
            n_tests++; if (got[15] !== 8'h77) begin n_fail++; $display("FAIL fullpop_drain_last: got %h want 77", got[15]); end
        end
        model_en = 1'b0;
    endtask

    task automatic test_reset_mid_transfer;
        int waited = 0;
        int npulse = 0;
        logic fell = 1'b0;
        do_reset();
        model_en = 1'b1;
        InValid = 1'b1;
        InData = 8'hA1; tick();
        InData = 8'hA2; tick();
        InData = 8'hA3; tick();
        InData = 8'hA4; tick();
        InValid = 1'b0;
        while (!TxBusy && waited < 20) begin tick(); waited++; end
        n_tests++; if (TxBusy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_rise: busy=%b want 1", TxBusy); end
        tick();
        tick();
        n_tests++; if (Level !== 5'd3) begin n_fail++; $display("FAIL midrst_queued: level=%0d want 3", Level); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_tests++; if (Level !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo: level=%0d empty=%b full=%b want 0/1/0", Level, Empty, Full); end
        n_tests++; if (TxDataValid !== 1'b0 || TxData !== 8'h00) begin n_fail++; $display("FAIL midrst_tx: valid=%b data=%h want 0/00", TxDataValid, TxData); end
        for (int c = 0; c < 40; c++) begin
            if (!TxBusy) fell = 1'b1;
            if (TxDataValid) npulse++;
            tick();
        end
        n_tests++; if (!fell || npulse != 0) begin n_fail++; $display("FAIL midrst_no_launch: busy_fell=%b pulses=%0d want 1/0", fell, npulse); end
        model_en = 1'b0;
    endtask

`ifdef FEEDER_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        int waited = 0;
        do_reset();
        tb_busy = 1'b0;
        push_byte(8'h5A);
        tick();
        n_tests++; if (Level !== 5'd0) begin n_fail++; $display("FAIL timeout_pop: level=%0d want 0", Level); end
        while (Timeout !== 1'b1 && n < TB_TIMEOUT + 10) begin tick(); n++; end
        n_tests++; if (Timeout !== 1'b1 || n != TB_TIMEOUT) begin n_fail++; $display("FAIL timeout_flag: timeout=%b after %0d cycles want 1 after %0d", Timeout, n, TB_TIMEOUT); end
        push_byte(8'h6B);
        while (TxDataValid !== 1'b1 && waited < 6) begin tick(); waited++; end
        n_tests++; if (TxDataValid !== 1'b1 || TxData !== 8'h6B) begin n_fail++; $display("FAIL timeout_relaunch: valid=%b data=%h want 1/6b", TxDataValid, TxData); end
        n_tests++; if (Timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", Timeout); end
    endtask
`endif

    initial begin
        model_en = 1'b0;
        tb_busy  = 1'b0;
        test_reset();
        test_single_launch();
        test_back_to_back();
        test_fill_overflow();
        test_full_pop_push();
        test_reset_mid_transfer();
`ifdef FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
